// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring-counter receive path.
// Index helpers work on 32-bit values so they serve any ring width up to 32.
package ring_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } ring_state_e;

    function automatic int unsigned next_pos(input int unsigned pos, input int unsigned width);
        return (pos == width - 1) ? 0 : pos + 1;
    endfunction

    // Lowest set bit wins; the caller decides separately whether the word is one-hot.
    function automatic int unsigned onehot_to_idx(input logic [31:0] vec);
        int unsigned pos;
        pos = 0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) pos = i;
        end
        return pos;
    endfunction

endpackage

// File: rtl/onehot_decode.sv
// Combinational one-hot check and position decode of a ring word.
// Kept free of state so other ring-style decoders can reuse it.
module onehot_decode
    import ring_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] ring_in,
    output logic             legal,
    output logic [IW-1:0]    idx
);

    assign legal = ($countones(ring_in) == 1);
    assign idx   = IW'(onehot_to_idx(32'(ring_in)));

endmodule

// File: rtl/ring_decoder_monitor.sv
// Ring-counter receive monitor: decodes position, tracks +1 stepping,
// and reports lock, wrap and step errors with a saturating error count.
//
//  state    | meaning
//  UNLOCKED | no reference position held
//  ACQUIRE  | one legal reference held, waiting for a +1 step
//  LOCKED   | stepping correctly; any deviation is an error
module ring_decoder_monitor
    import ring_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8,
    parameter int IW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ring_in,
    input  logic             ring_vld,
    output logic [IW-1:0]    idx,
    output logic             idx_vld,
    output logic             legal,
    output logic             locked,
    output logic             wrap,
    output logic             step_err,
    output logic [ERR_W-1:0] err_cnt
);

    ring_state_e      state_q, state_d;
    logic [IW-1:0]    prev_idx_q, prev_idx_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             idx_vld_q, idx_vld_d;
    logic             legal_q, legal_d;
    logic             wrap_q, wrap_d;
    logic             step_err_q, step_err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic             dec_legal;
    logic [IW-1:0]    dec_idx;
    logic [IW-1:0]    exp_idx;
    logic             step_ok;

    onehot_decode #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_decode (
        .ring_in (ring_in),
        .legal   (dec_legal),
        .idx     (dec_idx)
    );

    assign exp_idx = IW'(next_pos(32'(prev_idx_q), WIDTH));
    assign step_ok = dec_legal && (dec_idx == exp_idx);

    always_comb begin
        state_d    = state_q;
        prev_idx_d = prev_idx_q;
        idx_d      = idx_q;
        idx_vld_d  = 1'b0;
        legal_d    = legal_q;
        wrap_d     = 1'b0;
        step_err_d = 1'b0;
        err_cnt_d  = err_cnt_q;

        if (ring_vld) begin
            legal_d = dec_legal;
            // Every legal sample becomes the new reference, whatever the state does.
            if (dec_legal) begin
                idx_d      = dec_idx;
                idx_vld_d  = 1'b1;
                prev_idx_d = dec_idx;
            end

            unique case (state_q)
                UNLOCKED: begin
                    if (dec_legal) state_d = ACQUIRE;
                end
                ACQUIRE: begin
                    if (step_ok)         state_d = LOCKED;
                    else if (!dec_legal) state_d = UNLOCKED;
                end
                LOCKED: begin
                    if (step_ok) begin
                        wrap_d = (prev_idx_q == IW'(WIDTH - 1)) && (dec_idx == '0);
                    end else begin
                        state_d    = UNLOCKED;
                        step_err_d = 1'b1;
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= UNLOCKED;
            prev_idx_q <= '0;
            idx_q      <= '0;
            idx_vld_q  <= 1'b0;
            legal_q    <= 1'b0;
            wrap_q     <= 1'b0;
            step_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            prev_idx_q <= prev_idx_d;
            idx_q      <= idx_d;
            idx_vld_q  <= idx_vld_d;
            legal_q    <= legal_d;
            wrap_q     <= wrap_d;
            step_err_q <= step_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign idx      = idx_q;
    assign idx_vld  = idx_vld_q;
    assign legal    = legal_q;
    assign locked   = (state_q == LOCKED);
    assign wrap     = wrap_q;
    assign step_err = step_err_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_ring_decoder_monitor.sv
// Directed bench for ring_decoder_monitor with a streak-based reference model
// checked every cycle, plus literal expectations for the scripted scenarios.
module tb_ring_decoder_monitor;

    localparam int W  = 4;
    localparam int EW = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] ring_in = '0;
    logic         ring_vld = 1'b0;
    logic [1:0]   idx;
    logic         idx_vld, legal, locked, wrap, step_err;
    logic [EW-1:0] err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    ring_decoder_monitor #(.WIDTH(W), .ERR_W(EW)) dut (
        .clk      (clk),
        .reset    (reset),
        .ring_in  (ring_in),
        .ring_vld (ring_vld),
        .idx      (idx),
        .idx_vld  (idx_vld),
        .legal    (legal),
        .locked   (locked),
        .wrap     (wrap),
        .step_err (step_err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    // Model: streak counts consecutive legal samples forming a +1 chain
    // (0 = no reference, 1 = one reference, 2 = locked).
    int m_idx, m_vld, m_legal, m_wrap, m_serr, m_err, m_prev, m_streak;
    bit m_started = 0;

    always @(posedge clk) begin
        int cur, ones;
        bit lg, ok;
        if (reset) begin
            m_idx = 0; m_vld = 0; m_legal = 0; m_wrap = 0; m_serr = 0;
            m_err = 0; m_prev = 0; m_streak = 0; m_started = 1;
        end else begin
            m_vld = 0; m_wrap = 0; m_serr = 0;
            if (ring_vld) begin
                ones = 0; cur = 0;
                for (int i = 0; i < W; i++) if (ring_in[i]) begin ones++; cur = i; end
                lg = (ones == 1);
                ok = lg && (m_streak > 0) && (cur == (m_prev + 1) % W);
                m_legal = lg;
                if (m_streak >= 2 && !ok) begin
                    m_serr = 1;
                    m_err = (m_err < 255) ? m_err + 1 : 255;
                    m_streak = 0;
                end else if (ok) begin
                    if (m_streak >= 2 && m_prev == W - 1 && cur == 0) m_wrap = 1;
                    m_streak = 2;
                end else begin
                    m_streak = lg ? 1 : 0;
                end
                if (lg) begin
                    m_idx = cur; m_vld = 1; m_prev = cur;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("m_idx",      int'(idx),      m_idx);
            chk("m_idx_vld",  int'(idx_vld),  m_vld);
            chk("m_legal",    int'(legal),    m_legal);
            chk("m_locked",   int'(locked),   (m_streak >= 2) ? 1 : 0);
            chk("m_wrap",     int'(wrap),     m_wrap);
            chk("m_step_err", int'(step_err), m_serr);
            chk("m_err_cnt",  int'(err_cnt),  m_err);
        end
    end

    task automatic send(input logic [W-1:0] w);
        ring_in  = w;
        ring_vld = 1'b1;
        @(posedge clk); #1;
        ring_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        do_reset();
        chk("rst_idx", int'(idx), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_err", int'(err_cnt), 0);

        // 1: clean lock and wrap
        send(4'b0001); chk("t1_idx0", int'(idx), 0); chk("t1_lock0", int'(locked), 0);
        send(4'b0010); chk("t1_idx1", int'(idx), 1); chk("t1_lock1", int'(locked), 1);
        send(4'b0100); chk("t1_idx2", int'(idx), 2); chk("t1_wrap2", int'(wrap), 0);
        send(4'b1000); chk("t1_idx3", int'(idx), 3); chk("t1_wrap3", int'(wrap), 0);
        send(4'b0001); chk("t1_idx4", int'(idx), 0); chk("t1_wrap4", int'(wrap), 1);
        chk("t1_err", int'(err_cnt), 0);

        // 2: multi-hot while locked
        send(4'b0110);
        chk("t2_serr", int'(step_err), 1); chk("t2_legal", int'(legal), 0);
        chk("t2_idx", int'(idx), 0); chk("t2_lock", int'(locked), 0);
        chk("t2_err", int'(err_cnt), 1);
        send(4'b0001); send(4'b0010); chk("t2_relock", int'(locked), 1);

        // 3: skip from 1 to 3
        send(4'b1000);
        chk("t3_serr", int'(step_err), 1); chk("t3_idx", int'(idx), 3);
        chk("t3_lock", int'(locked), 0);
        send(4'b0001); chk("t3_acq", int'(locked), 0);
        send(4'b0010); chk("t3_relock", int'(locked), 1);

        // 4: gaps hold everything, then a stalled position
        idle(3);
        send(4'b0100); idle(3);
        chk("t4_hold_idx", int'(idx), 2); chk("t4_hold_vld", int'(idx_vld), 0);
        chk("t4_hold_lock", int'(locked), 1);
        send(4'b1000); idle(3);
        send(4'b0001); chk("t4_wrap", int'(wrap), 1); idle(3);
        chk("t4_wrap_gone", int'(wrap), 0);
        send(4'b0010); idle(3);
        send(4'b0100);
        send(4'b0100);
        chk("t4_stall_serr", int'(step_err), 1); chk("t4_stall_lock", int'(locked), 0);
        chk("t4_err", int'(err_cnt), 3);

        // 5: saturation
        for (int r = 0; r < 260; r++) begin
            send(4'b0001); send(4'b0010); send(4'b0110);
        end
        chk("t5_serr", int'(step_err), 1);
        chk("t5_sat", int'(err_cnt), 255);

        // 6: reset mid-sequence, including a sample presented during reset
        do_reset();
        for (int r = 0; r < 5; r++) begin
            send(4'b0001); send(4'b0010); send(4'b0110);
        end
        send(4'b0001); send(4'b0010);
        chk("t6_err5", int'(err_cnt), 5); chk("t6_locked", int'(locked), 1);
        reset = 1'b1; ring_in = 4'b0100; ring_vld = 1'b1;
        @(posedge clk); #1;
        chk("t6_rst_idx", int'(idx), 0); chk("t6_rst_lock", int'(locked), 0);
        chk("t6_rst_err", int'(err_cnt), 0); chk("t6_rst_legal", int'(legal), 0);
        @(posedge clk); #1;
        chk("t6_rst_vld", int'(idx_vld), 0);
        reset = 1'b0; ring_vld = 1'b0;
        send(4'b0001); chk("t6_acq", int'(locked), 0);
        send(4'b0010); chk("t6_relock", int'(locked), 1);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
